// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter.
//  uart_state_t    : transmitter frame state
//  UART_IDLE_LEVEL : level of the serial line while no bit is being sent
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } uart_state_t;

    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_tick.sv
// uart_tx_tick: serial UART transmitter paced by a one-cycle bit-rate strobe.
// Accepts a word on a valid/ready handshake and sends start, data (LSB first),
// optional parity and stop bits, each lasting exactly one tick period.
// Ports:
//  clk   : system clock, rising edge
//  rst   : synchronous active-high reset
//  tick  : bit-rate enable strobe, one clk wide (never used as a clock)
//  data  : word to send, sampled when valid && ready
//  valid : upstream has a word
//  ready : block can accept a word (registered)
//  tx    : serial line, idle high (registered)
//  busy  : frame in progress, from acceptance until the last stop bit ends
module uart_tx_tick
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  valid,
    output logic                  ready,
    output logic                  tx,
    output logic                  busy
);

    localparam int                CNT_W     = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic              LAST_STOP = (STOP_BITS == 2);

    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_data_width
        $error("uart_tx_tick: DATA_WIDTH must be in 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_tick: STOP_BITS must be 1 or 2");
    end
    if (PARITY_EN < 0 || PARITY_EN > 1) begin : g_bad_parity_en
        $error("uart_tx_tick: PARITY_EN must be 0 or 1");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
        $error("uart_tx_tick: PARITY_ODD must be 0 or 1");
    end

    // Parity bit for a word: even parity, inverted when odd parity is selected.
    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] word);
        return (^word) ^ (PARITY_ODD != 0);
    endfunction

    uart_state_t           state_q,    state_d;
    logic [DATA_WIDTH-1:0] shift_q,    shift_d;
    logic                  par_q,      par_d;
    logic [CNT_W-1:0]      bit_cnt_q,  bit_cnt_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  tx_q,       tx_d;
    logic                  ready_q,    ready_d;
    logic                  busy_q,     busy_d;

    // Next-state and output computation for the frame FSM.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        par_d      = par_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        ready_d    = ready_q;
        busy_d     = busy_q;

        case (state_q)
            IDLE: begin
                // A tick here is deliberately ignored: the word waits in ARMED
                // for the next full tick so the start bit is never shortened.
                if (valid && ready_q) begin
                    state_d = ARMED;
                    shift_d = data;
                    par_d   = calc_parity(data);
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ARMED: begin
                if (tick) begin
                    state_d = START;
                    tx_d    = 1'b0;
                end else begin
                    state_d = ARMED;
                end
            end
            START: begin
                // The shift register always presents the next data bit at bit 0.
                if (tick) begin
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[DATA_WIDTH-1:1]};
                    bit_cnt_d = '0;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d    = STOP;
                            tx_d       = UART_IDLE_LEVEL;
                            stop_cnt_d = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[DATA_WIDTH-1:1]};
                    end
                end else begin
                    state_d = DATA;
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d    = STOP;
                    tx_d       = UART_IDLE_LEVEL;
                    stop_cnt_d = 1'b0;
                end else begin
                    state_d = PARITY;
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        state_d = IDLE;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = UART_IDLE_LEVEL;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            par_q      <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= UART_IDLE_LEVEL;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    assign tx    = tx_q;
    assign ready = ready_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_tick.sv
// Testbench for uart_tx_tick. Three instances share clk, rst and a divide-by-4
// tick: u0 is 8N1, u1 is 8E2 (even parity, two stop bits), u2 is 8O1.
// Sent words are queued in a scoreboard; the line monitor pops each word,
// builds the expected frame and checks every bit lasts exactly 4 clk.
module tb_uart_tx_tick;

    localparam int BIT_CLK = 4;

    typedef struct {
        int         dut;
        logic [7:0] word;
    } txn_t;

    logic       clk;
    logic       rst;
    logic       tick;
    int         div_cnt;
    logic [7:0] data_r  [3];
    logic       valid_r [3];
    logic       ready_w [3];
    logic       tx_w    [3];
    logic       busy_w  [3];

    int   passes;
    int   fails;
    int   total;
    txn_t sb_q [$];

    int dut_par_en [3] = '{0, 1, 1};
    int dut_odd    [3] = '{0, 0, 1};
    int dut_stops  [3] = '{1, 2, 1};

    uart_tx_tick #(.DATA_WIDTH(8), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
        .clk(clk), .rst(rst), .tick(tick), .data(data_r[0]), .valid(valid_r[0]),
        .ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));
    uart_tx_tick #(.DATA_WIDTH(8), .STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
        .clk(clk), .rst(rst), .tick(tick), .data(data_r[1]), .valid(valid_r[1]),
        .ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));
    uart_tx_tick #(.DATA_WIDTH(8), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
        .clk(clk), .rst(rst), .tick(tick), .data(data_r[2]), .valid(valid_r[2]),
        .ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Divide-by-4 bit-rate strobe, changed on the falling edge.
    initial begin
        tick    = 1'b0;
        div_cnt = 0;
        forever begin
            @(negedge clk);
            div_cnt = (div_cnt + 1) % BIT_CLK;
            tick    = (div_cnt == BIT_CLK - 1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a word and hold valid until the DUT accepts it.
    task automatic send(input int d, input logic [7:0] w);
        logic acc;
        @(negedge clk);
        data_r[d]  = w;
        valid_r[d] = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 400 && !acc; n++) begin
            acc = (ready_w[d] === 1'b1);
            @(negedge clk);
        end
        valid_r[d] = 1'b0;
        check($sformatf("accept_d%0d_%02h", d, w), {31'd0, acc}, 32'd1);
        if (acc) begin
            sb_q.push_back('{d, w});
            check($sformatf("ready_low_d%0d", d), {31'd0, ready_w[d]}, 32'd0);
            check($sformatf("busy_high_d%0d", d), {31'd0, busy_w[d]}, 32'd1);
        end
    endtask

    // Pop one scoreboard entry and check the whole frame on that DUT's line.
    task automatic check_frame();
        txn_t t;
        logic q [$];
        logic ok;
        int   n;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        t = sb_q.pop_front();
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(t.word[i]);
        if (dut_par_en[t.dut] != 0) q.push_back((^t.word) ^ (dut_odd[t.dut] != 0));
        for (int i = 0; i < dut_stops[t.dut]; i++) q.push_back(1'b1);

        n = 0;
        while (tx_w[t.dut] !== 1'b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("start_seen_d%0d_%02h", t.dut, t.word), {31'd0, n < 60}, 32'd1);
        if (n >= 60) return;
        for (int i = 0; i < q.size(); i++) begin
            ok = 1'b1;
            for (int k = 0; k < BIT_CLK; k++) begin
                if (i != 0 || k != 0) @(negedge clk);
                if (tx_w[t.dut] !== q[i]) ok = 1'b0;
            end
            check($sformatf("d%0d_%02h_bit%0d_exp%0d", t.dut, t.word, i, q[i]), {31'd0, ok}, 32'd1);
        end
        check($sformatf("busy_last_stop_d%0d", t.dut), {31'd0, busy_w[t.dut]}, 32'd1);
        @(negedge clk);
        check($sformatf("ready_after_d%0d", t.dut), {31'd0, ready_w[t.dut]}, 32'd1);
        check($sformatf("busy_after_d%0d", t.dut), {31'd0, busy_w[t.dut]}, 32'd0);
    endtask

    // Accept a word a fixed number of clk after a tick and check start-bit latency/width.
    task automatic phase_test(input int offset, input int exp_lat);
        int   n;
        logic ok;
        n = 0;
        while (n < 8) begin
            @(posedge clk);
            n++;
            if (tick === 1'b1) break;
        end
        repeat (offset - 1) @(posedge clk);
        @(negedge clk);
        data_r[0]  = 8'h55;
        valid_r[0] = 1'b1;
        check($sformatf("phase%0d_ready", offset), {31'd0, ready_w[0]}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        valid_r[0] = 1'b0;
        @(posedge clk);
        #1;
        n = 1;
        while (tx_w[0] !== 1'b0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check($sformatf("phase%0d_latency", offset), n, exp_lat);
        ok = 1'b1;
        for (int k = 0; k < BIT_CLK - 1; k++) begin
            @(posedge clk);
            #1;
            if (tx_w[0] !== 1'b0) ok = 1'b0;
        end
        @(posedge clk);
        #1;
        if (tx_w[0] !== 1'b1) ok = 1'b0;
        check($sformatf("phase%0d_start_width", offset), {31'd0, ok}, 32'd1);
        n = 0;
        while (ready_w[0] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("phase%0d_done", offset), {31'd0, n < 100}, 32'd1);
    endtask

    initial begin
        passes = 0;
        fails  = 0;
        total  = 0;
        rst    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_r[i]  = 8'h00;
            valid_r[i] = 1'b0;
        end

        // Reset held 3 cycles with tick running.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("rst_tx_c%0d_d%0d", c, i), {31'd0, tx_w[i]}, 32'd1);
                check($sformatf("rst_ready_c%0d_d%0d", c, i), {31'd0, ready_w[i]}, 32'd1);
                check($sformatf("rst_busy_c%0d_d%0d", c, i), {31'd0, busy_w[i]}, 32'd0);
            end
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_tx", {31'd0, tx_w[0]}, 32'd1);
        check("post_rst_ready", {31'd0, ready_w[0]}, 32'd1);
        check("post_rst_busy", {31'd0, busy_w[0]}, 32'd0);

        // Basic 8N1 frame.
        send(0, 8'hA5);
        check_frame();

        // Parity variants: even parity with two stop bits, odd parity.
        send(1, 8'h07);
        check_frame();
        send(2, 8'h07);
        check_frame();

        // Handshake: next word held on valid while busy.
        send(0, 8'hA5);
        data_r[0]  = 8'h3C;
        valid_r[0] = 1'b1;
        check_frame();
        sb_q.push_back('{0, 8'h3C});
        @(negedge clk);
        valid_r[0] = 1'b0;
        data_r[0]  = 8'hFF;
        check("hs_ready_low", {31'd0, ready_w[0]}, 32'd0);
        check("hs_busy_high", {31'd0, busy_w[0]}, 32'd1);
        check_frame();

        // Reset during data bit 3 of 8'hFF, then a fresh frame.
        send(0, 8'hFF);
        void'(sb_q.pop_front());
        begin
            int n;
            n = 0;
            while (tx_w[0] !== 1'b0 && n < 60) begin
                @(negedge clk);
                n++;
            end
            check("midrst_start_seen", {31'd0, n < 60}, 32'd1);
        end
        repeat (4 * BIT_CLK) @(negedge clk);
        check("midrst_bit3_level", {31'd0, tx_w[0]}, 32'd1);
        check("midrst_busy_before", {31'd0, busy_w[0]}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_tx", {31'd0, tx_w[0]}, 32'd1);
        check("midrst_ready", {31'd0, ready_w[0]}, 32'd1);
        check("midrst_busy", {31'd0, busy_w[0]}, 32'd0);
        send(0, 8'h00);
        check_frame();

        // Tick phase: accept together with a tick, and one clk after a tick.
        phase_test(4, 4);
        phase_test(5, 3);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
